// File: rtl/laser_frame_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laser_frame_feeder_pkg
// Description : Shared frame geometry, player state encoding and point type
//               for the laser frame feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package laser_frame_feeder_pkg;

  // Points per frame; must equal the placement engine's read count.
  localparam int NUM_OBJ = 40;
  // Bits per X/Y coordinate.
  localparam int COORD_W = 4;
  // Point index counter width (covers 0..NUM_OBJ-1).
  localparam int CNT_W   = 6;
  // DONE-wait counter width.
  localparam int WAIT_W  = 16;

  // Player states.
  localparam logic [1:0] P_IDLE   = 2'd0;
  localparam logic [1:0] P_STREAM = 2'd1;
  localparam logic [1:0] P_WAIT   = 2'd2;

  // One target point as stored in a bank: Y in the upper half, X in the lower.
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

endpackage
`default_nettype wire

// File: rtl/laser_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : laser_pingpong_buf
// Description : Two NUM_OBJ-deep point banks used ping-pong. The write side
//               fills one bank while the read side plays out the other; a
//               bank is "full" from its last accepted point until released.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_pingpong_buf
  import laser_frame_feeder_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_accept,
  input  point_t           wr_data,
  output logic             wr_ready,
  input  logic [CNT_W-1:0] rd_addr,
  output point_t           rd_data,
  output logic             rd_full,
  input  logic             rd_release
);

  localparam logic [CNT_W-1:0] c_wr_last = CNT_W'(NUM_OBJ - 1);

  point_t           r_mem [0:1][0:NUM_OBJ-1];
  logic [1:0]       r_full;
  logic [1:0]       w_full_nxt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             w_wr_last;

  assign w_wr_last = wr_accept && (r_wr_cnt == c_wr_last);
  assign wr_ready  = !r_full[r_wr_bank];
  assign rd_full   = r_full[r_rd_bank];
  assign rd_data   = r_mem[r_rd_bank][rd_addr];

  // Full flags: completing a frame sets the write bank, release clears the read bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (rd_release) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  // Bank storage is never reset; stale contents are masked by the full flags.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      r_mem[r_wr_bank][r_wr_cnt] <= wr_data;
    end
  end

  // Write pointer, bank selectors and full flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (wr_accept) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        end
      end
      if (rd_release) begin
        r_rd_bank <= !r_rd_bank;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/laser_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module      : laser_frame_feeder
// Description : Collects streamed target points into 40-point frames and
//               plays each frame into the two-circle placement engine: engine
//               held in reset while idle, points on consecutive cycles, then a
//               wait for the engine DONE pulse (bounded by TIMEOUT).
// Revision    : 1.0 - initial release
// ============================================================================
module laser_frame_feeder
  import laser_frame_feeder_pkg::*;
#(
  parameter int TIMEOUT = 32767
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [COORD_W-1:0] IN_X,
  input  logic [COORD_W-1:0] IN_Y,
  output logic               LZ_RST,
  output logic [COORD_W-1:0] LZ_X,
  output logic [COORD_W-1:0] LZ_Y,
  input  logic               LZ_DONE,
  output logic [7:0]         FRAME_CNT,
  output logic               TIMEOUT_ERR
);

  localparam logic [CNT_W-1:0]  c_rd_last   = CNT_W'(NUM_OBJ - 1);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_wr_ready;
  logic              w_wr_accept;
  point_t            w_in_pt;
  logic [CNT_W-1:0]  w_rd_addr;
  point_t            w_rd_data;
  logic              w_rd_full;
  logic              w_done_hit;
  logic              w_timeout_hit;
  logic              w_release;
  logic              w_lz_rst_nxt;
  point_t            w_lz_pt_nxt;

  assign IN_READY    = w_wr_ready && !RST;
  assign w_wr_accept = IN_VALID && IN_READY;
  assign w_in_pt     = {IN_Y, IN_X};

  // Outputs are registered, so the bank is addressed one point ahead:
  // point 0 when leaving idle, point k+1 while point k is being loaded.
  assign w_rd_addr = (r_state == P_STREAM && r_rd_cnt != c_rd_last)
                     ? r_rd_cnt + CNT_W'(1) : '0;

  laser_pingpong_buf u_buf (
    .CLK        (CLK),
    .RST        (RST),
    .wr_accept  (w_wr_accept),
    .wr_data    (w_in_pt),
    .wr_ready   (w_wr_ready),
    .rd_addr    (w_rd_addr),
    .rd_data    (w_rd_data),
    .rd_full    (w_rd_full),
    .rd_release (w_release)
  );

  // Player state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= P_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Player next state; DONE wins over a coincident timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_done_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      P_IDLE: begin
        if (w_rd_full) begin
          w_state_nxt = P_STREAM;
        end
      end
      P_STREAM: begin
        if (r_rd_cnt == c_rd_last) begin
          w_state_nxt = P_WAIT;
        end
      end
      P_WAIT: begin
        if (LZ_DONE) begin
          w_state_nxt = P_IDLE;
          w_done_hit  = 1'b1;
        end else if (r_wait_cnt == c_wait_last) begin
          w_state_nxt   = P_IDLE;
          w_timeout_hit = 1'b1;
        end
      end
      default: w_state_nxt = P_IDLE;
    endcase
  end

  // Engine-facing values for the next cycle, derived from the next state.
  always_comb begin
    w_release    = w_done_hit || w_timeout_hit;
    w_lz_rst_nxt = (w_state_nxt == P_IDLE);
    w_lz_pt_nxt  = (w_state_nxt == P_STREAM) ? w_rd_data : '0;
  end

  // Counters, registered engine outputs and status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_cnt    <= '0;
      r_wait_cnt  <= '0;
      LZ_RST      <= 1'b1;
      LZ_X        <= '0;
      LZ_Y        <= '0;
      FRAME_CNT   <= 8'd0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      LZ_RST       <= w_lz_rst_nxt;
      {LZ_Y, LZ_X} <= w_lz_pt_nxt;
      r_rd_cnt     <= (r_state == P_STREAM && w_state_nxt == P_STREAM)
                      ? r_rd_cnt + CNT_W'(1) : '0;
      r_wait_cnt   <= (r_state == P_WAIT) ? r_wait_cnt + WAIT_W'(1) : '0;
      if (w_done_hit) begin
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      if (w_timeout_hit) begin
        TIMEOUT_ERR <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_frame_feeder
// Description : Bench for laser_frame_feeder. dut_a (default TIMEOUT) is
//               tracked cycle by cycle against a frame-queue model; dut_b
//               (TIMEOUT=64) exercises the DONE timeout with literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_frame_feeder;
  import laser_frame_feeder_pkg::*;

  localparam int TO_A = 32767;
  localparam int TO_B = 64;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       a_rst, a_valid, a_ready, a_lz_rst, a_done, a_terr;
  logic [3:0] a_x, a_y, a_lzx, a_lzy;
  logic [7:0] a_fcnt;
  logic       b_rst, b_valid, b_ready, b_lz_rst, b_done, b_terr;
  logic [3:0] b_x, b_y, b_lzx, b_lzy;
  logic [7:0] b_fcnt;

  laser_frame_feeder #(.TIMEOUT(TO_A)) dut_a (
    .CLK(CLK), .RST(a_rst), .IN_VALID(a_valid), .IN_READY(a_ready),
    .IN_X(a_x), .IN_Y(a_y), .LZ_RST(a_lz_rst), .LZ_X(a_lzx), .LZ_Y(a_lzy),
    .LZ_DONE(a_done), .FRAME_CNT(a_fcnt), .TIMEOUT_ERR(a_terr)
  );

  laser_frame_feeder #(.TIMEOUT(TO_B)) dut_b (
    .CLK(CLK), .RST(b_rst), .IN_VALID(b_valid), .IN_READY(b_ready),
    .IN_X(b_x), .IN_Y(b_y), .LZ_RST(b_lz_rst), .LZ_X(b_lzx), .LZ_Y(b_lzy),
    .LZ_DONE(b_done), .FRAME_CNT(b_fcnt), .TIMEOUT_ERR(b_terr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // ---------------- model of dut_a ----------------
  // m_fq holds complete, unreleased frames back to back (oldest first);
  // m_phase: -1 idle, 0..NUM_OBJ-1 point shown, NUM_OBJ+w = w-th wait cycle.
  logic [7:0] m_fq[$];
  logic [7:0] m_cur[$];
  int m_phase = -1;
  int m_fcnt = 0;
  bit m_terr = 1'b0;

  task automatic m_release();
    repeat (NUM_OBJ) void'(m_fq.pop_front());
    m_phase = -1;
  endtask

  task automatic model_step();
    int held;
    bit acc;
    held = m_fq.size() / NUM_OBJ;
    acc  = a_valid && !a_rst && (held < 2);
    if (a_rst) begin
      m_fq.delete();
      m_cur.delete();
      m_phase = -1;
      m_fcnt  = 0;
      m_terr  = 1'b0;
    end else begin
      if (m_phase < 0) begin
        if (held >= 1) m_phase = 0;
      end else if (m_phase < NUM_OBJ) begin
        m_phase++;
      end else if (a_done) begin
        m_fcnt = (m_fcnt + 1) % 256;
        m_release();
      end else if (m_phase - NUM_OBJ == TO_A - 1) begin
        m_terr = 1'b1;
        m_release();
      end else begin
        m_phase++;
      end
      if (acc) begin
        m_cur.push_back({a_y, a_x});
        if (m_cur.size() == NUM_OBJ) begin
          foreach (m_cur[k]) m_fq.push_back(m_cur[k]);
          m_cur.delete();
        end
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Per-cycle comparison of every dut_a output against the model.
  logic [7:0] e_pt;
  logic       e_ready, e_lzrst;
  initial forever begin
    @(negedge CLK);
    if (cmp_en) begin
      e_ready = !a_rst && (m_fq.size() < 2 * NUM_OBJ);
      e_lzrst = (m_phase < 0);
      e_pt    = (m_phase >= 0 && m_phase < NUM_OBJ) ? m_fq[m_phase] : 8'h00;
      check("cmp_in_ready", a_ready, e_ready);
      check("cmp_lz_rst", a_lz_rst, e_lzrst);
      check("cmp_lz_x", a_lzx, e_pt[3:0]);
      check("cmp_lz_y", a_lzy, e_pt[7:4]);
      check("cmp_frame_cnt", a_fcnt, m_fcnt[7:0]);
      check("cmp_timeout_err", a_terr, m_terr);
    end
  end

  // ---------------- dut_a stream source ----------------
  logic [7:0] src_q[$];
  int hs_cnt = 0;
  int last_hs_cyc = 0;
  initial begin
    a_valid = 1'b0;
    a_x = '0;
    a_y = '0;
    forever begin : drv
      bit hs;
      @(negedge CLK);
      hs = a_valid && a_ready;
      if (hs) begin
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      @(posedge CLK);
      if (hs) void'(src_q.pop_front());
      #1;
      if (src_q.size() > 0) begin
        a_valid = 1'b1;
        {a_y, a_x} = src_q[0];
      end else begin
        a_valid = 1'b0;
        a_x = '0;
        a_y = '0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int k = 0;
    while (hs_cnt < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (hs_cnt < n) bound_fail(name);
  endtask

  task automatic wait_phase(input int p, input int budget, input string name);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (m_phase != p && k < budget);
    if (m_phase != p) bound_fail(name);
  endtask

  // LZ_DONE high for exactly the next full cycle.
  task automatic pulse_a_done();
    @(posedge CLK); #1 a_done = 1'b1;
    @(posedge CLK); #1 a_done = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  int c, s, base, c0, b_miss;
  initial begin
    a_rst = 1'b1; a_done = 1'b0;
    b_rst = 1'b1; b_done = 1'b0; b_valid = 1'b0; b_x = '0; b_y = '0;
    @(posedge CLK); #1 cmp_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", a_ready, 1'b0);
    check("rst_lz_rst", a_lz_rst, 1'b1);
    check("rst_lz_xy", {a_lzy, a_lzx}, 8'h00);
    check("rst_frame_cnt", a_fcnt, 8'd0);
    check("rst_timeout_err", a_terr, 1'b0);
    @(posedge CLK); #1 a_rst = 1'b0; b_rst = 1'b0;

    // One frame, X=i%16 Y=i/16, then DONE 100 cycles after the last point.
    for (int i = 0; i < NUM_OBJ; i++) src_q.push_back({4'(i / 16), 4'(i % 16)});
    wait_hs(NUM_OBJ, 200, "t1_handshakes");
    c = last_hs_cyc;
    wait_cyc(c + 1);
    check("t1_still_idle", a_lz_rst, 1'b1);
    wait_cyc(c + 2);
    check("t1_lat_lz_rst", a_lz_rst, 1'b0);
    check("t1_lat_p0", {a_lzy, a_lzx}, 8'h00);
    wait_cyc(c + 2 + 17);
    check("t1_p17", {a_lzy, a_lzx}, 8'h11);
    wait_cyc(c + 2 + 39);
    check("t1_p39", {a_lzy, a_lzx}, 8'h27);
    s = c + 2 + 39;
    wait_cyc(s + 1);
    check("t1_wait_lz_rst", a_lz_rst, 1'b0);
    check("t1_wait_xy", {a_lzy, a_lzx}, 8'h00);
    wait_cyc(s + 99);
    pulse_a_done();
    @(negedge CLK);
    check("t2_frame_cnt", a_fcnt, 8'd1);
    check("t2_lz_rst", a_lz_rst, 1'b1);
    check("t2_timeout_err", a_terr, 1'b0);

    // DONE while idle and while streaming is ignored.
    pulse_a_done();
    for (int i = 0; i < NUM_OBJ; i++) src_q.push_back({4'(15 - i % 16), 4'((i + 3) % 16)});
    wait_phase(10, 200, "t6_reach_p10");
    pulse_a_done();
    wait_phase(NUM_OBJ + 5, 200, "t6_reach_wait");
    check("t6_cnt_unchanged", a_fcnt, 8'd1);
    check("t6_in_wait", a_lz_rst, 1'b0);
    pulse_a_done();
    @(negedge CLK);
    check("t6_cnt_after_done", a_fcnt, 8'd2);

    // Three frames back to back; third stalls until the first DONE.
    base = hs_cnt;
    for (int i = 0; i < 3 * NUM_OBJ; i++) src_q.push_back({4'((i / 8) % 16), 4'(i % 16)});
    wait_hs(base + 2 * NUM_OBJ, 400, "t3_two_frames");
    repeat (60) @(negedge CLK);
    check("t3_stall_ready", a_ready, 1'b0);
    check("t3_stall_count", hs_cnt, base + 2 * NUM_OBJ);
    pulse_a_done();
    @(negedge CLK);
    check("t3_cnt_a", a_fcnt, 8'd3);
    wait_hs(base + 3 * NUM_OBJ, 300, "t3_third_frame");
    wait_phase(NUM_OBJ + 5, 300, "t3_wait_b");
    pulse_a_done();
    wait_phase(NUM_OBJ + 5, 300, "t3_wait_c");
    pulse_a_done();
    @(negedge CLK);
    check("t3_cnt_final", a_fcnt, 8'd5);

    // Reset while point 20 is on the engine bus.
    for (int i = 0; i < NUM_OBJ; i++) src_q.push_back({4'd9, 4'(i % 16)});
    wait_phase(19, 300, "t5_reach_p19");
    @(posedge CLK); #1 a_rst = 1'b1;
    @(posedge CLK); #1 a_rst = 1'b0;
    @(negedge CLK);
    check("t5_lz_rst", a_lz_rst, 1'b1);
    check("t5_lz_xy", {a_lzy, a_lzx}, 8'h00);
    check("t5_frame_cnt", a_fcnt, 8'd0);
    base = hs_cnt;
    for (int i = 0; i < NUM_OBJ; i++) src_q.push_back({4'(i % 16), 4'(15 - i % 16)});
    wait_hs(base + NUM_OBJ, 200, "t5_fresh_frame");
    wait_phase(0, 50, "t5_fresh_p0");
    check("t5_fresh_p0", {a_lzy, a_lzx}, 8'h0f);
    wait_phase(NUM_OBJ + 5, 100, "t5_fresh_wait");
    pulse_a_done();
    @(negedge CLK);
    check("t5_cnt_after", a_fcnt, 8'd1);

    // dut_b: engine never answers, TIMEOUT=64.
    b_miss = 0;
    for (int i = 0; i < 2 * NUM_OBJ; i++) begin
      @(posedge CLK); #1;
      b_valid = 1'b1;
      b_x = 4'(i % 16);
      b_y = 4'((i + 5) % 16);
      @(negedge CLK);
      if (!b_ready) b_miss++;
      if (i == NUM_OBJ - 1) c0 = cyc;
      if (i == NUM_OBJ + 1) begin
        check("t4_p0_lz_rst", b_lz_rst, 1'b0);
        check("t4_p0", {b_lzy, b_lzx}, 8'h50);
      end
    end
    @(posedge CLK); #1 b_valid = 1'b0;
    check("t4_ready_all", b_miss, 0);
    wait_cyc(c0 + 105);
    check("t4_before_to_err", b_terr, 1'b0);
    check("t4_before_to_rst", b_lz_rst, 1'b0);
    wait_cyc(c0 + 106);
    check("t4_to_err", b_terr, 1'b1);
    check("t4_to_lz_rst", b_lz_rst, 1'b1);
    check("t4_to_frame_cnt", b_fcnt, 8'd0);
    wait_cyc(c0 + 107);
    check("t4_next_lz_rst", b_lz_rst, 1'b0);
    check("t4_next_p0", {b_lzy, b_lzx}, 8'hd8);
    wait_cyc(c0 + 107 + 39);
    check("t4_next_p39", {b_lzy, b_lzx}, 8'h4f);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
